// File: rtl/uart_pkg.sv
// Shared UART constants used as parameter defaults by the receive path.
package uart_pkg;

    localparam int UART_DATA_W   = 8;
    localparam int RX_FIFO_DEPTH = 16;

endpackage : uart_pkg

// File: rtl/edge_detect.sv
// Rising-edge strobe generator: one-cycle pulse per low-to-high transition of sig.
module edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic strobe
);

    logic sig_q;

    // Resets high so a level already asserted at reset release does not strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 1'b1;
        end else begin
            sig_q <= sig;
        end
    end

    assign strobe = sig & ~sig_q;

endmodule : edge_detect

// File: rtl/rx_fifo.sv
// Receive byte buffer between the RX stage and its consumer, first-word-fall-through,
// one write per RX_READY rising edge, sticky overrun on writes into a full buffer.
module rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = RX_FIFO_DEPTH,
    parameter int SIZE  = UART_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rx_ready,
    input  logic [SIZE-1:0]          dq,
    input  logic                     rd_ready,
    input  logic                     clr_ovr,
    output logic                     rd_valid,
    output logic [SIZE-1:0]          rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overrun
);

    localparam int AW = $clog2(DEPTH);

    logic [SIZE-1:0] mem [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic            wr;
    logic            pop;
    logic            push;
    logic            ovr_set;

    edge_detect u_edge_detect (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig    (rx_ready),
        .strobe (wr)
    );

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count    = wr_ptr - rd_ptr;
    assign rd_valid = ~empty;
    assign rd_data  = mem[rd_ptr[AW-1:0]];

    // A pop on the same edge frees the slot, so a full buffer still accepts that write.
    assign pop     = rd_valid & rd_ready;
    assign push    = wr & (~full | pop);
    assign ovr_set = wr & full & ~pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= dq;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            overrun <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule : rx_fifo

// File: tb/tb_rx_fifo.sv
// Directed self-checking bench for rx_fifo with hand-computed expectations.
module tb_rx_fifo;

    localparam int DEPTH = 16;
    localparam int SIZE  = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            rx_ready;
    logic [SIZE-1:0] dq;
    logic            rd_ready;
    logic            clr_ovr;
    logic            rd_valid;
    logic [SIZE-1:0] rd_data;
    logic [4:0]      count;
    logic            full;
    logic            empty;
    logic            overrun;

    int n_checks = 0;
    int n_fail   = 0;
    logic mon_en = 1'b0;
    int   max_cnt = 0;

    rx_fifo #(.DEPTH(DEPTH), .SIZE(SIZE)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_ready (rx_ready),
        .dq       (dq),
        .rd_ready (rd_ready),
        .clr_ovr  (clr_ovr),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en && int'(count) > max_cnt) max_cnt = int'(count);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle RX_READY pulse followed by one idle cycle.
    task automatic send_byte(input logic [7:0] b);
        dq = b;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        tick();
    endtask

    task automatic pop_one();
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; rx_ready = 1'b0; dq = '0; rd_ready = 1'b0; clr_ovr = 1'b0;
        repeat (3) tick();
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_valid", 32'(rd_valid), 0);
        check("rst_ovr", 32'(overrun), 0);
        rst_n = 1'b1;
        tick();

        // Single byte with 3-cycle RX_READY pulse
        dq = 8'hA5; rx_ready = 1'b1;
        #1;
        check("nobypass_valid", 32'(rd_valid), 0);
        tick();
        check("single_valid", 32'(rd_valid), 1);
        check("single_data", 32'(rd_data), 32'hA5);
        check("single_count", 32'(count), 1);
        tick(); tick();
        check("single_one_write", 32'(count), 1);
        rx_ready = 1'b0;
        tick();
        pop_one();
        check("single_empty", 32'(empty), 1);

        // RD_READY while empty must not underflow
        rd_ready = 1'b1;
        tick(); tick();
        rd_ready = 1'b0;
        check("underflow_count", 32'(count), 0);
        check("underflow_empty", 32'(empty), 1);

        // Streaming with continuous RD_READY, wraps pointers
        rd_ready = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            dq = 8'(i + 8'h40);
            rx_ready = 1'b1;
            tick();
            check("wrap_data", 32'(rd_data), 32'(i + 8'h40));
            rx_ready = 1'b0;
            tick();
            check("wrap_drained", 32'(count), 0);
        end
        mon_en = 1'b0;
        rd_ready = 1'b0;
        check("wrap_max_count", 32'(max_cnt), 1);

        // Fill and overrun
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        check("fill_full", 32'(full), 1);
        check("fill_count", 32'(count), 16);
        check("fill_ovr_clear", 32'(overrun), 0);
        send_byte(8'h10);
        check("ovr_count", 32'(count), 16);
        check("ovr_set", 32'(overrun), 1);
        for (int i = 0; i < 16; i++) begin
            check("drain_data", 32'(rd_data), 32'(i));
            pop_one();
        end
        check("drain_empty", 32'(empty), 1);
        check("ovr_sticky", 32'(overrun), 1);

        // Overrun clear
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        check("ovr_cleared", 32'(overrun), 0);

        // Full with simultaneous write and pop
        for (int i = 0; i < 16; i++) send_byte(8'(8'h20 + i));
        check("coinc_pre_full", 32'(full), 1);
        dq = 8'h5A; rx_ready = 1'b1; rd_ready = 1'b1;
        tick();
        rx_ready = 1'b0; rd_ready = 1'b0;
        check("coinc_count", 32'(count), 16);
        check("coinc_full", 32'(full), 1);
        check("coinc_ovr", 32'(overrun), 0);
        tick();
        for (int i = 1; i < 16; i++) begin
            check("coinc_data", 32'(rd_data), 32'(8'h20 + i));
            pop_one();
        end
        check("coinc_last", 32'(rd_data), 32'h5A);
        pop_one();
        check("coinc_empty", 32'(empty), 1);

        // Clear coincident with a new overrun: set wins
        for (int i = 0; i < 16; i++) send_byte(8'(8'h80 + i));
        dq = 8'hEE; rx_ready = 1'b1; clr_ovr = 1'b1;
        tick();
        rx_ready = 1'b0; clr_ovr = 1'b0;
        check("ovr_set_wins", 32'(overrun), 1);
        check("ovr_drop_count", 32'(count), 16);
        tick();

        // Reset mid-stream with RX_READY held high
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) send_byte(8'(8'hC0 + i));
        check("mid_count5", 32'(count), 5);
        dq = 8'h99; rx_ready = 1'b1; rst_n = 1'b0;
        #1;
        check("mid_async_count", 32'(count), 0);
        tick(); tick();
        check("mid_empty", 32'(empty), 1);
        check("mid_ovr", 32'(overrun), 0);
        rst_n = 1'b1;
        tick(); tick(); tick();
        check("mid_no_write", 32'(count), 0);
        rx_ready = 1'b0;
        tick();
        dq = 8'h77; rx_ready = 1'b1;
        tick();
        check("mid_new_count", 32'(count), 1);
        check("mid_new_data", 32'(rd_data), 32'h77);
        rx_ready = 1'b0;
        pop_one();
        check("mid_final_empty", 32'(empty), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_rx_fifo
